// File: rtl/ase_umsg_seq.sv
// ase_umsg_seq: per-slot UMsg hint/data sequencer with delay timers and a round-robin output arbiter.
module ase_umsg_seq #(
  parameter int NUM_UMSG = 8,
  parameter int TIMER_W  = 8,
  parameter int DATA_W   = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  input  logic [$clog2(NUM_UMSG)-1:0] cmd_id,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [NUM_UMSG-1:0] hint_en,
  input  logic [TIMER_W-1:0]  hint_delay,
  input  logic [TIMER_W-1:0]  data_delay,
  input  logic                out_free,
  output logic                umsg_valid,
  output logic                umsg_hint,
  output logic [$clog2(NUM_UMSG)-1:0] umsg_id,
  output logic [DATA_W-1:0]   umsg_data,
  output logic                cmd_drop,
  output logic [NUM_UMSG-1:0] busy
);
  localparam int IDW = $clog2(NUM_UMSG);
  typedef enum logic [2:0] {S_IDLE, S_HWAIT, S_SHINT, S_DWAIT, S_SDATA} state_t;
  state_t              r_st   [NUM_UMSG];
  logic [TIMER_W-1:0]  r_tmr  [NUM_UMSG];
  logic [DATA_W-1:0]   r_data [NUM_UMSG];
  logic [IDW-1:0]      r_last;
  logic [NUM_UMSG-1:0] w_req, w_take, w_sel;
  logic                w_gnt;
  logic [IDW-1:0]      w_gid, w_idx;
  genvar i;
  generate
    for (i = 0; i < NUM_UMSG; i++) begin : g_slot
      assign w_req[i]  = r_st[i] == S_SHINT || r_st[i] == S_SDATA;
      assign busy[i]   = r_st[i] != S_IDLE;
      assign w_take[i] = cmd_valid && cmd_id == IDW'(i) && r_st[i] == S_IDLE;
    end
  endgenerate
  // Search starts just above the last winner; IDW-bit addition wraps modulo NUM_UMSG.
  always_comb begin
    w_gnt = 1'b0;
    w_gid = '0;
    w_idx = '0;
    for (int k = 1; k <= NUM_UMSG; k++) begin
      w_idx = r_last + IDW'(k);
      if (out_free && w_req[w_idx] && !w_gnt) begin
        w_gnt = 1'b1;
        w_gid = w_idx;
      end
    end
    w_sel = '0;
    if (w_gnt) w_sel[w_gid] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_UMSG; s++) begin
        r_st[s]   <= S_IDLE;
        r_tmr[s]  <= '0;
        r_data[s] <= '0;
      end
      r_last     <= IDW'(NUM_UMSG - 1);
      umsg_valid <= 1'b0;
      umsg_hint  <= 1'b0;
      umsg_id    <= '0;
      umsg_data  <= '0;
      cmd_drop   <= 1'b0;
    end else begin
      umsg_valid <= w_gnt;
      umsg_hint  <= w_gnt && r_st[w_gid] == S_SHINT;
      umsg_id    <= w_gid;
      umsg_data  <= (w_gnt && r_st[w_gid] == S_SDATA) ? r_data[w_gid] : '0;
      cmd_drop   <= cmd_valid && !(|w_take);
      if (w_gnt) r_last <= w_gid;
      for (int s = 0; s < NUM_UMSG; s++) begin
        case (r_st[s])
          S_IDLE: if (w_take[s]) begin
            r_data[s] <= cmd_data;
            r_st[s]   <= hint_en[s] ? S_HWAIT : S_DWAIT;
            r_tmr[s]  <= hint_en[s] ? hint_delay : data_delay;
          end
          S_HWAIT, S_DWAIT: if (r_tmr[s] == '0) r_st[s] <= (r_st[s] == S_HWAIT) ? S_SHINT : S_SDATA;
                            else r_tmr[s] <= r_tmr[s] - 1'b1;
          S_SHINT: if (w_sel[s]) begin
            r_st[s]  <= S_DWAIT;
            r_tmr[s] <= data_delay;
          end
          S_SDATA: if (w_sel[s]) r_st[s] <= S_IDLE;
          default: r_st[s] <= S_IDLE;
        endcase
      end
    end
  end
endmodule
